// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter for the shared data RAM, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority to m0.
module ram_arbiter #(
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        ram_r,
    output logic [3:0]  ram_w,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_out,
    input  logic [31:0] ram_in
);
    localparam int CW = RAM_LAT > 1 ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          id, win;
    logic [3:0]    we;
    logic [31:0]   addr, wdata;
    logic          start;

    assign start = state == IDLE && (m0_req || m1_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic last;
    // last holds the port granted most recently; it loses the next tie
    assign win = (m0_req && m1_req) ? ~last : m1_req;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last <= 1'b1;
        else if (start)
            last <= win;
`else
    assign win = ~m0_req;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx  = state;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        ram_r     = 1'b0;
        ram_w     = 4'b0;
        case (state)
            IDLE:   state_nx = start ? ACCESS : IDLE;
            ACCESS: begin
                state_nx = WAIT;
                m0_gnt   = ~id;
                m1_gnt   = id;
                ram_r    = ~|we;
                ram_w    = we;
            end
            WAIT:   state_nx = cnt == '0 ? RESP : WAIT;
            RESP: begin
                state_nx  = IDLE;
                m0_rvalid = ~id;
                m1_rvalid = id;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ram_addr = addr;
    assign ram_out  = wdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            id       <= 1'b0;
            we       <= 4'b0;
            addr     <= 32'b0;
            wdata    <= 32'b0;
            cnt      <= '0;
            m0_rdata <= 32'b0;
            m1_rdata <= 32'b0;
        end else begin
            if (start) begin
                id    <= win;
                we    <= win ? m1_we : m0_we;
                addr  <= win ? m1_addr : m0_addr;
                wdata <= win ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS)
                cnt <= CW'(RAM_LAT - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            // writes leave the port's rdata untouched
            if (state == WAIT && cnt == '0 && we == 4'b0) begin
                if (id)
                    m1_rdata <= ram_in;
                else
                    m0_rdata <= ram_in;
            end
        end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter at RAM_LAT=1 (dut_a) and RAM_LAT=3 (dut_b).
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic        req[2];
    logic [3:0]  mwe[2];
    logic [31:0] maddr[2], mwdata[2];
    logic        gnt[2][2], rvalid[2][2];
    logic [31:0] rdata[2][2];
    logic        rr[2];
    logic [3:0]  rw[2];
    logic [31:0] raddr[2], rout[2], rin[2];

    ram_arbiter #(.RAM_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0] & ~sel), .m0_we(mwe[0]), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
        .m0_gnt(gnt[0][0]), .m0_rvalid(rvalid[0][0]), .m0_rdata(rdata[0][0]),
        .m1_req(req[1] & ~sel), .m1_we(mwe[1]), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
        .m1_gnt(gnt[0][1]), .m1_rvalid(rvalid[0][1]), .m1_rdata(rdata[0][1]),
        .ram_r(rr[0]), .ram_w(rw[0]), .ram_addr(raddr[0]), .ram_out(rout[0]), .ram_in(rin[0])
    );

    ram_arbiter #(.RAM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0] & sel), .m0_we(mwe[0]), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
        .m0_gnt(gnt[1][0]), .m0_rvalid(rvalid[1][0]), .m0_rdata(rdata[1][0]),
        .m1_req(req[1] & sel), .m1_we(mwe[1]), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
        .m1_gnt(gnt[1][1]), .m1_rvalid(rvalid[1][1]), .m1_rdata(rdata[1][1]),
        .ram_r(rr[1]), .ram_w(rw[1]), .ram_addr(raddr[1]), .ram_out(rout[1]), .ram_in(rin[1])
    );

    // RAM models: byte-enabled write at the access edge, read data after the DUT's latency
    logic [31:0] mem[2][256];
    logic [31:0] pipe[2][3];
    always @(posedge clk)
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 4; b++)
                if (rw[d][b]) mem[d][raddr[d][9:2]][8*b +: 8] <= rout[d][8*b +: 8];
            pipe[d][0] <= rr[d] ? mem[d][raddr[d][9:2]] : 32'h0;
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    assign rin[0] = pipe[0][0];
    assign rin[1] = pipe[1][2];

    logic        cg[2], cv[2];
    logic [31:0] cd[2];
    logic        c_r;
    logic [3:0]  c_w;
    logic [31:0] c_addr;
    assign cg[0]  = gnt[sel][0];
    assign cg[1]  = gnt[sel][1];
    assign cv[0]  = rvalid[sel][0];
    assign cv[1]  = rvalid[sel][1];
    assign cd[0]  = rdata[sel][0];
    assign cd[1]  = rdata[sel][1];
    assign c_r    = rr[sel];
    assign c_w    = rw[sel];
    assign c_addr = raddr[sel];

    typedef struct {int port; bit rd; logic [31:0] data; int at;} exp_t;
    exp_t q[$];
    exp_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk)
        if (rst_n) begin
            for (int p = 0; p < 2; p++)
                if (cv[p]) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rvalid: got rvalid on port %0d expected none (cycle %0d)", p, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("rvalid_port", p, e.port);
                        chk("rvalid_cycle", cyc, e.at);
                        if (e.rd) chk("rdata", cd[p], e.data);
                    end
                end
            if (c_r || |c_w) chk("strobe_excl", {31'b0, c_r && |c_w}, 32'b0);
        end

    task automatic drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", q.size(), 0);
        q.delete();
    endtask

    task automatic txn(input int p, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
        int lat = sel ? 3 : 1;
        int r;
        bit got = 0;
        @(posedge clk);
        #1;
        req[p] = 1'b1; mwe[p] = we; maddr[p] = addr; mwdata[p] = wd;
        r = cyc;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cg[p]) begin
                got = 1;
                chk("gnt_latency", cyc, r + 1);
                chk("gnt_other", {31'b0, cg[1-p]}, 32'b0);
                chk("ram_w", {28'b0, c_w}, {28'b0, we});
                chk("ram_r", {31'b0, c_r}, {31'b0, we == 4'b0});
                chk("ram_addr", c_addr, addr);
                q.push_back('{p, we == 4'b0, exp_rd, cyc + 1 + lat});
            end
        end
        chk("gnt_seen", {31'b0, got}, 32'd1);
        @(negedge clk);
        chk("strobe_1cyc", {27'b0, c_r, c_w}, 32'b0);
        @(posedge clk);
        #1 req[p] = 1'b0;
        drain();
    endtask

    initial begin
        int n;
        int p;
        bit got;
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; mwe[i] = 0; maddr[i] = 0; mwdata[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {26'b0, gnt[0][0], gnt[0][1], rvalid[0][0], rvalid[0][1], rr[0], rr[1]}, 32'b0);
        chk("reset_ram_w", {24'b0, rw[0], rw[1]}, 32'b0);
        chk("reset_rdata", rdata[0][0] | rdata[0][1] | raddr[0] | rout[0], 32'b0);
        rst_n = 1'b1;

        // reset asserted mid-WAIT drops the transaction
        @(posedge clk);
        #1;
        req[0] = 1; mwe[0] = 4'hF; maddr[0] = 32'h100; mwdata[0] = 32'h11111111;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = cg[0];
        end
        chk("rst_test_gnt", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1 req[0] = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", {28'b0, gnt[0][0], rvalid[0][0], rr[0], |rw[0]}, 32'b0);
        chk("rst_async_addr", raddr[0], 32'b0);
        chk("rst_async_out", rout[0], 32'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_rvalid_after_rst", {30'b0, cv[0], cv[1]}, 32'b0);
        end

        txn(0, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0);
        txn(0, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF);
        txn(1, 4'b0010, 32'h100, 32'h0000AB00, 32'h0);
        txn(1, 4'hF, 32'h200, 32'h12345678, 32'h0);
        chk("rdata_hold", cd[0], 32'hDEADBEEF);
        txn(0, 4'h0, 32'h100, 32'h0, 32'hDEADABEF);
        txn(1, 4'h0, 32'h200, 32'h0, 32'h12345678);

        // both masters request continuously
        @(posedge clk);
        #1;
        mwe[0] = 0; maddr[0] = 32'h100; mwe[1] = 0; maddr[1] = 32'h200;
        req[0] = 1; req[1] = 1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (cg[0] || cg[1]) begin
                p = cg[1] ? 1 : 0;
`ifdef ARB_ROUND_ROBIN_EN
                chk("arb_order", p, n % 2);
`else
                chk("arb_order", p, 0);
`endif
                q.push_back('{p, 1'b1, p == 1 ? 32'h12345678 : 32'hDEADABEF, cyc + 2});
                n++;
            end
        end
        chk("arb_count", n, 4);
        @(posedge clk);
        #1 begin req[0] = 0; req[1] = 0; end
        drain();

        repeat (10) begin
            @(negedge clk);
            chk("idle_bus", {25'b0, c_r, c_w, cg[0], cg[1]}, 32'b0);
        end

        sel = 1'b1;
        txn(0, 4'hF, 32'h40, 32'hCAFEF00D, 32'h0);
        txn(0, 4'h0, 32'h40, 32'h0, 32'hCAFEF00D);
        txn(1, 4'h0, 32'h40, 32'h0, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
